// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and the writeback-side load
// extender: FSM state encoding, RISC-V funct3 access codes and the 2-bit
// memory write-enable size codes.
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] WE_NONE = 2'b00;
   localparam logic [1:0] WE_B    = 2'b01;
   localparam logic [1:0] WE_H    = 2'b10;
   localparam logic [1:0] WE_W    = 2'b11;

   // Memory write-enable size code for a funct3 access width.
   function automatic logic [1:0] size_code(input logic [2:0] funct3);
      logic [1:0] code;
      case (funct3)
         F3_B, F3_BU: code = WE_B;
         F3_H, F3_HU: code = WE_H;
         F3_W:        code = WE_W;
         default:     code = WE_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Purely combinational: selects the low byte/half/word of a raw memory word
// and sign- or zero-extends it according to the load funct3.
// Ports:
//   funct3_i  load funct3 (B, H, W, BU, HU); anything else yields 0
//   raw_i     raw little-endian memory word, addressed byte in [7:0]
//   ext_o     extended load result
// ---------------------------------------------------------------------------
module load_extend
   import lsu_pkg::*;
#(
   parameter int RegBits = 32
) (
   input  logic [2:0]         funct3_i,
   input  logic [RegBits-1:0] raw_i,
   output logic [RegBits-1:0] ext_o
);

   // Width selection and extension.
   always_comb begin
      ext_o = '0;
      case (funct3_i)
         F3_B:    ext_o = {{(RegBits-8){raw_i[7]}}, raw_i[7:0]};
         F3_BU:   ext_o = {{(RegBits-8){1'b0}}, raw_i[7:0]};
         F3_H:    ext_o = {{(RegBits-16){raw_i[15]}}, raw_i[15:0]};
         F3_HU:   ext_o = {{(RegBits-16){1'b0}}, raw_i[15:0]};
         F3_W:    ext_o = raw_i;
         default: ext_o = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Core-side initiator for the byte-addressable data memory. Takes one
// load/store from execute over valid/ready, checks funct3 legality,
// alignment and range, performs a single-cycle memory access and returns an
// extended load result (or an error) over a second valid/ready handshake.
// Only one transaction is ever in flight: IDLE -> ACCESS -> RESP.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*               request handshake and fields from execute
//   resp_*              response handshake, data and error to writeback
//   mem_a_o/mem_wd_o    memory byte address / write data (held outside ACCESS)
//   mem_we_o            write size code, nonzero only in ACCESS of a store
//   mem_rd_i            combinational read data, bytes a..a+3 little-endian
// ---------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int RegBits  = 32,
   parameter int MemBytes = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [2:0]         req_funct3_i,
   input  logic [RegBits-1:0] req_addr_i,
   input  logic [RegBits-1:0] req_wdata_i,
   output logic               resp_valid_o,
   input  logic               resp_ready_i,
   output logic [RegBits-1:0] resp_rdata_o,
   output logic               resp_err_o,
   output logic [RegBits-1:0] mem_a_o,
   output logic [RegBits-1:0] mem_wd_o,
   output logic [1:0]         mem_we_o,
   input  logic [RegBits-1:0] mem_rd_i
);

   // One extra bit so addr + span never wraps past the top of the space.
   localparam logic [RegBits:0] LAST_ADDR = (RegBits+1)'(MemBytes - 1);

   lsu_state_e         state_q, state_d;
   logic [2:0]         f3_q, f3_d;
   logic               we_q, we_d;
   logic [RegBits-1:0] mem_a_q, mem_a_d;
   logic [RegBits-1:0] mem_wd_q, mem_wd_d;
   logic [1:0]         mem_we_q, mem_we_d;
   logic [RegBits-1:0] rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;

   logic               f3_ok_s;
   logic               align_ok_s;
   logic [RegBits:0]   span_s;
   logic [RegBits:0]   last_byte_s;
   logic               req_legal_s;
   logic [RegBits-1:0] ext_s;

   load_extend #(
      .RegBits (RegBits)
   ) u_load_extend (
      .funct3_i (f3_q),
      .raw_i    (mem_rd_i),
      .ext_o    (ext_s)
   );

   // Request legality: funct3 code, natural alignment and last byte in range.
   always_comb begin
      f3_ok_s    = 1'b0;
      align_ok_s = 1'b1;
      span_s     = '0;
      case (req_funct3_i)
         F3_B: begin
            f3_ok_s = 1'b1;
         end
         F3_BU: begin
            f3_ok_s = ~req_we_i;
         end
         F3_H: begin
            f3_ok_s    = 1'b1;
            align_ok_s = (req_addr_i[0] == 1'b0);
            span_s     = {{(RegBits-1){1'b0}}, 2'd1};
         end
         F3_HU: begin
            f3_ok_s    = ~req_we_i;
            align_ok_s = (req_addr_i[0] == 1'b0);
            span_s     = {{(RegBits-1){1'b0}}, 2'd1};
         end
         F3_W: begin
            f3_ok_s    = 1'b1;
            align_ok_s = (req_addr_i[1:0] == 2'b00);
            span_s     = {{(RegBits-1){1'b0}}, 2'd3};
         end
         default: begin
            f3_ok_s = 1'b0;
         end
      endcase
      last_byte_s = {1'b0, req_addr_i} + span_s;
      req_legal_s = f3_ok_s & align_ok_s & (last_byte_s <= LAST_ADDR);
   end

   // Next-state and next-output decode for the three-state transaction FSM.
   always_comb begin
      state_d  = state_q;
      f3_d     = f3_q;
      we_d     = we_q;
      mem_a_d  = mem_a_q;
      mem_wd_d = mem_wd_q;
      mem_we_d = WE_NONE;
      rdata_d  = rdata_q;
      err_d    = err_q;
      valid_d  = valid_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               f3_d = req_funct3_i;
               we_d = req_we_i;
               if (req_legal_s) begin
                  // Memory port only moves for requests that will access it.
                  mem_a_d = req_addr_i;
                  if (req_we_i) begin
                     mem_wd_d = req_wdata_i;
                     mem_we_d = size_code(req_funct3_i);
                  end else begin
                     mem_we_d = WE_NONE;
                  end
                  state_d = ACCESS;
               end else begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  valid_d = 1'b1;
                  state_d = RESP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            // Store commits and load data is captured at the edge ending ACCESS.
            err_d   = 1'b0;
            rdata_d = we_q ? '0 : ext_s;
            valid_d = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready_i) begin
               valid_d = 1'b0;
               err_d   = 1'b0;
               rdata_d = '0;
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            rdata_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset also kills an in-flight write enable.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         f3_q     <= 3'b000;
         we_q     <= 1'b0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         mem_we_q <= WE_NONE;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         f3_q     <= f3_d;
         we_q     <= we_d;
         mem_a_q  <= mem_a_d;
         mem_wd_q <= mem_wd_d;
         mem_we_q <= mem_we_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = valid_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;
   assign mem_a_o      = mem_a_q;
   assign mem_wd_o     = mem_wd_q;
   assign mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Bench for load_store_unit with a behavioural byte memory attached to the
// memory port and a separate byte-array reference model of what memory
// should contain. Directed scenarios first, then randomized transactions.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int RB = 32;
   localparam int MB = 1024;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic          req_we_i;
   logic [2:0]    req_funct3_i;
   logic [RB-1:0] req_addr_i;
   logic [RB-1:0] req_wdata_i;
   logic          resp_valid_o;
   logic          resp_ready_i;
   logic [RB-1:0] resp_rdata_o;
   logic          resp_err_o;
   logic [RB-1:0] mem_a_o;
   logic [RB-1:0] mem_wd_o;
   logic [1:0]    mem_we_o;
   logic [RB-1:0] mem_rd_i;

   logic [7:0] mem     [0:MB-1];
   logic [7:0] ref_mem [0:MB-1];

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;

   load_store_unit #(.RegBits(RB), .MemBytes(MB)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .mem_a_o      (mem_a_o),
      .mem_wd_o     (mem_wd_o),
      .mem_we_o     (mem_we_o),
      .mem_rd_i     (mem_rd_i)
   );

   always #5 clk_i = ~clk_i;

   // Combinational memory read port: bytes a..a+3, zero beyond the array.
   always_comb begin
      logic [32:0] idx;
      mem_rd_i = '0;
      for (int k = 0; k < 4; k++) begin
         idx = {1'b0, mem_a_o} + 33'(k);
         mem_rd_i[8*k +: 8] = (idx < 33'(MB)) ? mem[idx[9:0]] : 8'h00;
      end
   end

   // Memory write port; counts every cycle with a nonzero write enable.
   always @(posedge clk_i) begin
      if (mem_we_o != 2'b00) begin
         wr_cnt <= wr_cnt + 1;
         mem[mem_a_o[9:0]] <= mem_wd_o[7:0];
         if (mem_we_o[1]) mem[mem_a_o[9:0] + 10'd1] <= mem_wd_o[15:8];
         if (mem_we_o == 2'b11) begin
            mem[mem_a_o[9:0] + 10'd2] <= mem_wd_o[23:16];
            mem[mem_a_o[9:0] + 10'd3] <= mem_wd_o[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: legality and expected load value straight from the access rules.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 output bit legal, output logic [31:0] rd, output int size);
      longint      last;
      int unsigned v;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      last  = longint'({32'd0, addr}) + size - 1;
      legal = (size != 0) && !(we && f3[2]) && !(size == 2 && addr[0]) &&
              !(size == 4 && addr[1:0] != 2'b00) && (last <= MB - 1);
      rd = 32'd0;
      if (legal && !we) begin
         v = 0;
         for (int i = size - 1; i >= 0; i--) v = v * 256 + ref_mem[addr[9:0] + 10'(i)];
         if (f3 == 3'd0 && v >= 128)   v = v + 32'hFFFFFF00;
         if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
         rd = v;
      end
   endfunction

   // One full transaction with `hold` cycles of back-pressure in RESP.
   task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold, output logic [31:0] got);
      bit          legal;
      logic [31:0] exp_rd;
      int          size;
      int          w0;
      int          lat;
      model(we, f3, addr, legal, exp_rd, size);
      @(negedge clk_i);
      chk({tag, ".ready_idle"}, 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wd;
      resp_ready_i = 1'b1;
      w0 = wr_cnt;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      if (legal) begin
         chk({tag, ".we_access"}, 32'(mem_we_o), we ? ((size == 1) ? 32'd1 : (size == 2) ? 32'd2 : 32'd3) : 32'd0);
         chk({tag, ".addr"}, mem_a_o, addr);
         if (we) chk({tag, ".wdata"}, mem_wd_o, wd);
         chk({tag, ".ready_access"}, 32'(req_ready_o), 32'd0);
         chk({tag, ".valid_access"}, 32'(resp_valid_o), 32'd0);
      end
      lat = 1;
      while (resp_valid_o !== 1'b1 && lat < 8) begin
         @(posedge clk_i); #1;
         lat++;
      end
      resp_ready_i = 1'b0;
      chk({tag, ".latency"}, 32'(lat), legal ? 32'd2 : 32'd1);
      chk({tag, ".rdata"}, resp_rdata_o, exp_rd);
      chk({tag, ".err"}, 32'(resp_err_o), legal ? 32'd0 : 32'd1);
      chk({tag, ".we_resp"}, 32'(mem_we_o), 32'd0);
      got = resp_rdata_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         req_valid_i  = 1'b1;
         req_we_i     = 1'b1;
         req_funct3_i = 3'b010;
         req_addr_i   = 32'h40;
         req_wdata_i  = $urandom;
         @(posedge clk_i); #1;
         chk({tag, ".hold_valid"}, 32'(resp_valid_o), 32'd1);
         chk({tag, ".hold_rdata"}, resp_rdata_o, exp_rd);
         chk({tag, ".hold_err"}, 32'(resp_err_o), legal ? 32'd0 : 32'd1);
         chk({tag, ".hold_ready"}, 32'(req_ready_o), 32'd0);
      end
      @(negedge clk_i);
      req_valid_i  = 1'b0;
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
      chk({tag, ".valid_done"}, 32'(resp_valid_o), 32'd0);
      chk({tag, ".ready_done"}, 32'(req_ready_o), 32'd1);
      chk({tag, ".writes"}, 32'(wr_cnt - w0), (legal && we) ? 32'd1 : 32'd0);
      if (legal && we)
         for (int i = 0; i < size; i++) ref_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
   endtask

   task automatic reset_values(input string tag);
      chk({tag, ".we"}, 32'(mem_we_o), 32'd0);
      chk({tag, ".valid"}, 32'(resp_valid_o), 32'd0);
      chk({tag, ".rdata"}, resp_rdata_o, 32'd0);
      chk({tag, ".err"}, 32'(resp_err_o), 32'd0);
      chk({tag, ".a"}, mem_a_o, 32'd0);
      chk({tag, ".wd"}, mem_wd_o, 32'd0);
      chk({tag, ".ready"}, 32'(req_ready_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [7:0]  b;
      logic [31:0] a;
      int          w0;
      rst_i        = 1'b1;
      req_valid_i  = 1'b0;
      req_we_i     = 1'b0;
      req_funct3_i = 3'b000;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      resp_ready_i = 1'b0;
      for (int i = 0; i < MB; i++) begin
         b = 8'($urandom);
         mem[i] <= b;
         ref_mem[i] = b;
      end
      mem[16'h10] <= 8'hBB; ref_mem[16'h10] = 8'hBB;
      mem[16'h11] <= 8'hAA; ref_mem[16'h11] = 8'hAA;
      mem[16'h12] <= 8'h99; ref_mem[16'h12] = 8'h99;
      mem[16'h13] <= 8'h88; ref_mem[16'h13] = 8'h88;
      #1;
      reset_values("por");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Loads of the known pattern.
      txn("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 0, got);  chk("lb13.const", got, 32'hFFFFFF88);
      txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 0, got); chk("lbu13.const", got, 32'h00000088);
      txn("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 0, got);  chk("lh12.const", got, 32'hFFFF8899);
      txn("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 0, got);  chk("lw10.const", got, 32'h8899AABB);

      // Halfword store then word readback.
      txn("sh20", 1'b1, 3'b001, 32'h20, 32'h12345678, 0, got);
      txn("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 0, got);  chk("lw20.low", {16'h0, got[15:0]}, 32'h00005678);

      // Error cases.
      txn("sh21", 1'b1, 3'b001, 32'h21, 32'hCAFEF00D, 0, got);
      txn("sw22", 1'b1, 3'b010, 32'h22, 32'hCAFEF00D, 0, got);
      txn("lw3fe", 1'b0, 3'b010, 32'h3FE, 32'h0, 0, got);
      txn("lb400", 1'b0, 3'b000, 32'h400, 32'h0, 0, got);
      txn("lwtop", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 0, got);
      txn("sb011", 1'b1, 3'b011, 32'h24, 32'h11, 0, got);
      txn("sb100", 1'b1, 3'b100, 32'h24, 32'h11, 0, got);
      txn("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 0, got);

      // Back-pressure with an ignored request.
      txn("lw10hold", 1'b0, 3'b010, 32'h10, 32'h0, 3, got); chk("lw10hold.const", got, 32'h8899AABB);

      // Reset during the ACCESS cycle of a store.
      @(negedge clk_i);
      req_valid_i  = 1'b1;
      req_we_i     = 1'b1;
      req_funct3_i = 3'b010;
      req_addr_i   = 32'h30;
      req_wdata_i  = 32'hDEADBEEF;
      w0 = wr_cnt;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("rst.we_before", 32'(mem_we_o), 32'd3);
      #2;
      rst_i = 1'b1;
      #1;
      reset_values("rst.async");
      @(posedge clk_i); #1;
      reset_values("rst.held");
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rst.no_write", 32'(wr_cnt - w0), 32'd0);
      txn("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 0, got);

      // Randomized traffic, biased toward the interesting address region.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            1:       a = 32'($urandom_range(MB - 8, MB + 4));
            default: a = 32'($urandom_range(0, 63));
         endcase
         if ($urandom_range(0, 1) == 0) a = a & 32'hFFFFFFFC;
         txn("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 2), got);
      end

      // Read back the random-write region against the reference.
      for (int w = 0; w < 16; w++)
         txn("scan", 1'b0, 3'b010, 32'(w * 4), 32'h0, 0, got);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
